// File: rtl/mem_agu_queue.sv
// Memory address generation unit with a DEPTH-entry in-order output queue.
// Optional synchronous queue flush is enabled by defining MEM_AGU_QUEUE_FLUSH_EN.
module mem_agu_queue #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int ROB_W  = 5,
    parameter int PREG_W = 5,
    parameter int ARCH_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
`ifdef MEM_AGU_QUEUE_FLUSH_EN
    input  logic                         flush,
`endif
    input  logic [3:0]                   opcode,
    input  logic [ROB_W-1:0]             ROB_entry,
    input  logic [ADDR_W-1:0]            base_val,
    input  logic [7:0]                   offset,
    input  logic [PREG_W-1:0]            dest_reg,
    input  logic [DATA_W-1:0]            data,
    input  logic [3:0]                   imm,
    input  logic [ARCH_W-1:0]            dest_arch_regs,
    input  logic                         input_valid,
    output logic                         input_ready,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [PREG_W-1:0]            dest_reg_out,
    output logic [DATA_W-1:0]            data_out,
    output logic [ARCH_W-1:0]            dest_arch_regs_out,
    output logic [ROB_W-1:0]             ROB_entry_out,
    output logic                         store_out,
    output logic                         page_cross_out,
    output logic                         output_valid,
    input  logic                         output_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              page_cross;
        logic              store;
        logic [PREG_W-1:0] dest_reg;
        logic [DATA_W-1:0] data;
        logic [ARCH_W-1:0] arch_regs;
        logic [ROB_W-1:0]  rob;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    // Returns {page_cross, effective_address}. Wrap mode keeps the page bits
    // and never reports a crossing; linear mode reports the carry out of bit 7.
    function automatic logic [ADDR_W:0] agu_calc(
        input logic [ADDR_W-1:0] base,
        input logic [7:0]        off,
        input logic              wrap
    );
        logic [8:0]        low_sum;
        logic [ADDR_W-1:0] addr;
        low_sum = {1'b0, base[7:0]} + {1'b0, off};
        if (wrap) begin
            addr = {base[ADDR_W-1:8], low_sum[7:0]};
            return {1'b0, addr};
        end else begin
            addr = base + {{(ADDR_W-8){1'b0}}, off};
            return {low_sum[8], addr};
        end
    endfunction

    entry_t             mem_r [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [CNT_W-1:0]   count_r;

    entry_t             entry_s;
    entry_t             head_s;
    logic [ADDR_W:0]    agu_s;
    logic               flush_s;
    logic               empty_s;
    logic               full_s;
    logic               ready_s;
    logic               push_s;
    logic               pop_s;
    logic               unused_inputs_s;

`ifdef MEM_AGU_QUEUE_FLUSH_EN
    assign flush_s = flush;
`else
    assign flush_s = 1'b0;
`endif

    assign unused_inputs_s = ^{opcode[3:1], imm[2:0]};

    // Handshake decode; flush blocks acceptance so a dropped push never lands.
    always_comb begin
        empty_s = (count_r == CNT_ZERO);
        full_s  = (count_r == CNT_FULL);
        if (flush_s) begin
            ready_s = 1'b0;
        end else begin
            ready_s = !full_s || output_ready;
        end
        push_s = input_valid && ready_s;
        pop_s  = !empty_s && output_ready && !flush_s;
    end

    // Build the entry captured on push.
    always_comb begin
        agu_s             = agu_calc(base_val, offset, imm[3]);
        entry_s.addr       = agu_s[ADDR_W-1:0];
        entry_s.page_cross = agu_s[ADDR_W];
        entry_s.store      = opcode[0];
        entry_s.dest_reg   = dest_reg;
        entry_s.data       = data;
        entry_s.arch_regs  = dest_arch_regs;
        entry_s.rob        = ROB_entry;
    end

    // Pointer and occupancy state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= CNT_ZERO;
        end else if (flush_s) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= CNT_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; deliberately not reset since empty gating hides it.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= entry_s;
        end
    end

    // Head selection, forced to zero whenever the queue is empty.
    always_comb begin
        if (empty_s) begin
            head_s = entry_t'({ENTRY_W{1'b0}});
        end else begin
            head_s = mem_r[rd_ptr_r];
        end
    end

    assign input_ready        = ready_s;
    assign output_valid       = !empty_s;
    assign count              = count_r;
    assign mem_addr           = head_s.addr;
    assign page_cross_out     = head_s.page_cross;
    assign store_out          = head_s.store;
    assign dest_reg_out       = head_s.dest_reg;
    assign data_out           = head_s.data;
    assign dest_arch_regs_out = head_s.arch_regs;
    assign ROB_entry_out      = head_s.rob;

endmodule

// File: tb/tb_mem_agu_queue.sv
// Self-checking bench for mem_agu_queue: queue-based reference model compared
// every cycle, plus directed literal checks. Honours MEM_AGU_QUEUE_FLUSH_EN.
module tb_mem_agu_queue;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
`ifdef MEM_AGU_QUEUE_FLUSH_EN
    logic        flush;
`endif
    logic [3:0]  opcode;
    logic [4:0]  ROB_entry;
    logic [15:0] base_val;
    logic [7:0]  offset;
    logic [4:0]  dest_reg;
    logic [7:0]  data;
    logic [3:0]  imm;
    logic [7:0]  dest_arch_regs;
    logic        input_valid;
    logic        input_ready;
    logic [15:0] mem_addr;
    logic [4:0]  dest_reg_out;
    logic [7:0]  data_out;
    logic [7:0]  dest_arch_regs_out;
    logic [4:0]  ROB_entry_out;
    logic        store_out;
    logic        page_cross_out;
    logic        output_valid;
    logic        output_ready;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    mem_agu_queue dut (
        .clk(clk), .rst_n(rst_n),
`ifdef MEM_AGU_QUEUE_FLUSH_EN
        .flush(flush),
`endif
        .opcode(opcode), .ROB_entry(ROB_entry), .base_val(base_val),
        .offset(offset), .dest_reg(dest_reg), .data(data), .imm(imm),
        .dest_arch_regs(dest_arch_regs), .input_valid(input_valid),
        .input_ready(input_ready), .mem_addr(mem_addr),
        .dest_reg_out(dest_reg_out), .data_out(data_out),
        .dest_arch_regs_out(dest_arch_regs_out), .ROB_entry_out(ROB_entry_out),
        .store_out(store_out), .page_cross_out(page_cross_out),
        .output_valid(output_valid), .output_ready(output_ready), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int pc;
        int st;
        int dreg;
        int dat;
        int arch;
        int rob;
    } ent_t;

    ent_t q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_ready();
        int r;
        r = (q.size() != DEPTH || output_ready) ? 1 : 0;
`ifdef MEM_AGU_QUEUE_FLUSH_EN
        if (flush) r = 0;
`endif
        return r;
    endfunction

    // Reference model: address rules applied with plain integer arithmetic.
    always @(posedge clk) begin
        if (rst_n) begin
            int  do_push;
            int  do_pop;
            int  b;
            int  o;
            bit  fl;
            ent_t e;
            fl = 1'b0;
`ifdef MEM_AGU_QUEUE_FLUSH_EN
            fl = flush;
`endif
            do_push = (input_valid && model_ready() != 0) ? 1 : 0;
            do_pop  = (q.size() != 0 && output_ready) ? 1 : 0;
            b = int'(base_val);
            o = int'(offset);
            if (imm[3]) begin
                e.addr = (b / 256) * 256 + ((b % 256 + o) % 256);
                e.pc   = 0;
            end else begin
                e.addr = (b + o) % 65536;
                e.pc   = ((b % 256) + o >= 256) ? 1 : 0;
            end
            e.st   = int'(opcode[0]);
            e.dreg = int'(dest_reg);
            e.dat  = int'(data);
            e.arch = int'(dest_arch_regs);
            e.rob  = int'(ROB_entry);
            if (fl) begin
                q.delete();
            end else begin
                if (do_pop != 0) void'(q.pop_front());
                if (do_push != 0) q.push_back(e);
            end
        end
    end

    always @(negedge rst_n) q.delete();

    // Compare process: every cycle, on the inactive edge.
    always @(negedge clk) begin
        ent_t h;
        check("count", 32'(count), 32'(q.size()));
        check("output_valid", 32'(output_valid), (q.size() != 0) ? 32'd1 : 32'd0);
        check("input_ready", 32'(input_ready), 32'(model_ready()));
        if (q.size() != 0) begin
            h = q[0];
        end else begin
            h = '{0, 0, 0, 0, 0, 0, 0};
        end
        check("mem_addr", 32'(mem_addr), 32'(h.addr));
        check("page_cross_out", 32'(page_cross_out), 32'(h.pc));
        check("store_out", 32'(store_out), 32'(h.st));
        check("dest_reg_out", 32'(dest_reg_out), 32'(h.dreg));
        check("data_out", 32'(data_out), 32'(h.dat));
        check("dest_arch_regs_out", 32'(dest_arch_regs_out), 32'(h.arch));
        check("ROB_entry_out", 32'(ROB_entry_out), 32'(h.rob));
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input bit st, input int rob, input int base,
                         input int off, input bit wrap);
        input_valid    = v;
        opcode         = {3'b101, st};
        ROB_entry      = 5'(rob);
        base_val       = 16'(base);
        offset         = 8'(off);
        dest_reg       = 5'(rob + 3);
        data           = 8'(rob * 7 + 1);
        dest_arch_regs = 8'(rob) ^ 8'h5A;
        imm            = {wrap, 3'b011};
    endtask

    initial begin
        rst_n = 1'b0;
`ifdef MEM_AGU_QUEUE_FLUSH_EN
        flush = 1'b0;
`endif
        output_ready = 1'b0;
        drive(1'b0, 1'b0, 0, 0, 0, 1'b0);
        step();
        check("reset_count", 32'(count), 32'd0);
        check("reset_valid", 32'(output_valid), 32'd0);
        check("reset_addr", 32'(mem_addr), 32'd0);
        rst_n = 1'b1;
        step();

        // Page-wrap mode load
        drive(1'b1, 1'b0, 3, 16'h12F0, 8'h20, 1'b1);
        imm = 4'b1000;
        step();
        drive(1'b0, 1'b0, 0, 0, 0, 1'b0);
        check("wrap_addr", 32'(mem_addr), 32'h1210);
        check("wrap_pc", 32'(page_cross_out), 32'd0);
        check("wrap_store", 32'(store_out), 32'd0);
        check("wrap_valid", 32'(output_valid), 32'd1);

        // Linear mode, pushed together with popping the wrap entry
        output_ready = 1'b1;
        drive(1'b1, 1'b1, 6, 16'h12F0, 8'h20, 1'b0);
        step();
        check("lin_addr", 32'(mem_addr), 32'h1310);
        check("lin_pc", 32'(page_cross_out), 32'd1);
        check("lin_count", 32'(count), 32'd1);
        drive(1'b1, 1'b0, 8, 16'hFFFF, 8'h01, 1'b0);
        imm = 4'b0000;
        step();
        check("lin_wrap_addr", 32'(mem_addr), 32'h0000);
        drive(1'b0, 1'b0, 0, 0, 0, 1'b0);
        step();
        check("drained_valid", 32'(output_valid), 32'd0);
        check("drained_rob", 32'(ROB_entry_out), 32'd0);

        // Fill and back-pressure
        output_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 1'b1, i, 16'h2000 + i, i, 1'b0);
            step();
        end
        check("full_count", 32'(count), 32'd4);
        check("full_ready", 32'(input_ready), 32'd0);
        drive(1'b1, 1'b0, 9, 16'h3000, 8'h10, 1'b0);
        step();
        check("ignored_count", 32'(count), 32'd4);
        check("ignored_head", 32'(ROB_entry_out), 32'd1);
        drive(1'b0, 1'b0, 0, 0, 0, 1'b0);
        output_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("drain_order", 32'(ROB_entry_out), 32'(i));
            step();
        end
        check("drain_empty", 32'(output_valid), 32'd0);

        // Full with simultaneous pop
        output_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 1'b0, i, 16'h4000, i * 16, 1'b1);
            step();
        end
        output_ready = 1'b1;
        drive(1'b1, 1'b1, 5, 16'h40F8, 8'h10, 1'b0);
        #1;
        check("full_pop_ready", 32'(input_ready), 32'd1);
        step();
        drive(1'b0, 1'b0, 0, 0, 0, 1'b0);
        check("full_pop_count", 32'(count), 32'd4);
        for (int i = 2; i <= 5; i++) begin
            check("full_pop_order", 32'(ROB_entry_out), 32'(i));
            step();
        end
        check("full_pop_empty", 32'(output_valid), 32'd0);

        // Reset mid-operation
        output_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 1'b0, 20 + i, 16'h5000, i, 1'b0);
            step();
        end
        drive(1'b0, 1'b0, 0, 0, 0, 1'b0);
        check("pre_reset_count", 32'(count), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_valid", 32'(output_valid), 32'd0);
        check("async_reset_count", 32'(count), 32'd0);
        step();
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 7, 16'h0100, 8'h02, 1'b0);
        step();
        drive(1'b0, 1'b0, 0, 0, 0, 1'b0);
        check("post_reset_rob", 32'(ROB_entry_out), 32'd7);
        check("post_reset_count", 32'(count), 32'd1);
        check("post_reset_addr", 32'(mem_addr), 32'h0102);
        output_ready = 1'b1;
        step();

`ifdef MEM_AGU_QUEUE_FLUSH_EN
        output_ready = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            drive(1'b1, 1'b0, 10 + i, 16'h6000, i, 1'b0);
            step();
        end
        drive(1'b1, 1'b1, 12, 16'h6100, 8'h05, 1'b0);
        flush = 1'b1;
        #1;
        check("flush_ready", 32'(input_ready), 32'd0);
        step();
        flush = 1'b0;
        drive(1'b0, 1'b0, 0, 0, 0, 1'b0);
        check("flush_count", 32'(count), 32'd0);
        check("flush_valid", 32'(output_valid), 32'd0);
        step();
        check("flush_stays_empty", 32'(count), 32'd0);
`endif

        // Mixed traffic, checked by the model
        for (int i = 0; i < 48; i++) begin
            output_ready = (i % 4 != 0);
            drive((i % 3 != 2), i[0], i % 32, 16'h00F8 + i * 517, (i * 29) % 256, (i % 5 == 0));
            step();
        end
        drive(1'b0, 1'b0, 0, 0, 0, 1'b0);
        output_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        check("final_empty", 32'(count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_agu_queue.md
Name: mem_agu_queue

Overview:
- Parametrised successor to the single-stage memory address pipeline.
- Computes effective addresses for load/store micro-ops and buffers the results in a DEPTH-entry in-order queue ahead of the memory port, so short memory-side stalls do not back-pressure the scheduler.
- Adds page-cross reporting and configurable widths.
- Sits between the memory reservation station and the load/store unit.

Parameters:
- ADDR_W, 16, address width; must be at least 9.
- DATA_W, 8, store data width.
- ROB_W, 5, ROB index width.
- PREG_W, 5, physical register tag width.
- ARCH_W, 8, destination architectural register mask width.
- DEPTH, 4, queue entries; power of two, at least 2.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- opcode  in  4  bit 0 = store (1) / load (0); other bits ignored.
- ROB_entry  in  ROB_W  ROB tag.
- base_val  in  ADDR_W  base address.
- offset  in  8  unsigned index.
- dest_reg  in  PREG_W  destination physical register.
- data  in  DATA_W  store data.
- imm  in  4  bit 3 = page-wrap mode; other bits ignored.
- dest_arch_regs  in  ARCH_W  architectural register mask.
- input_valid  in  1  upstream valid.
- input_ready  out  1  accept strobe.
- mem_addr  out  ADDR_W  effective address of head entry.
- dest_reg_out  out  PREG_W  head field.
- data_out  out  DATA_W  head field.
- dest_arch_regs_out  out  ARCH_W  head field.
- ROB_entry_out  out  ROB_W  head field.
- store_out  out  1  head is a store.
- page_cross_out  out  1  head address carried out of the low byte (non-wrap mode only).
- output_valid  out  1  queue non-empty.
- output_ready  in  1  downstream ready.
- count  out  $clog2(DEPTH+1)  occupancy.

Behaviour:
- **Reset:** rst_n low asynchronously clears occupancy, read pointer and write pointer, and forces output_valid=0 and count=0. Entry storage is not cleared, but all head-field outputs must read 0 while count==0, so the head mux is gated by empty.
- **Handshakes:**
  - push = input_valid & input_ready.
  - pop = output_valid & output_ready.
  - input_ready = (count != DEPTH) | output_ready. When full, a push is accepted only together with a pop in the same cycle.
- **Address arithmetic**, computed at push:
  - imm[3]=1: low byte = (base_val[7:0] + offset) mod 256; upper ADDR_W-8 bits = base_val upper bits unchanged; page_cross=0.
  - imm[3]=0: addr = (base_val + zero-extended offset) mod 2^ADDR_W; page_cross = carry out of bit 7.
  - All other fields are captured verbatim. store = opcode[0].
- **Latency:** a pushed entry becomes visible at the head on the cycle after the push edge. There is no combinational bypass from input to output.
- **Ordering:** strict FIFO. Pointers wrap modulo DEPTH.
- **Simultaneous push and pop:** count is unchanged; both pointers advance.
  - With count==1, the popped entry leaves and the new entry is at the head next cycle.
  - With count==0, a push and pop cannot coincide because output_valid=0.
- **Head stability:** output_valid and all head fields hold stable while output_valid & !output_ready.
- **Ignored inputs:**
  - input_valid while input_ready=0: the data is ignored, with no side effects.
  - Input fields while input_valid=0: don't-care.
- **Reset mid-operation:** all queued entries are discarded and no partial pops occur. The first push after rst_n deasserts is visible one cycle later as usual.

Optional Feature:
- Macro: MEM_AGU_QUEUE_FLUSH_EN.
- When defined:
  - Adds input port flush (1 bit). flush=1 at a rising edge synchronously empties the queue (count=0, pointers equal).
  - flush has priority over push and pop in the same cycle: any push that cycle is dropped, and input_ready is forced to 0 while flush=1.
  - output_valid drops the cycle after the flush edge.
- When undefined: no flush port, and the queue empties only by pops or reset.

Test Plan:
- **Page-wrap mode:** imm=4'b1000, base_val=16'h12F0, offset=8'h20, load -> next cycle mem_addr=16'h1210, page_cross_out=0, store_out=0, output_valid=1.
- **Linear mode:** imm=0, base_val=16'h12F0, offset=8'h20 -> mem_addr=16'h1310, page_cross_out=1. Also base_val=16'hFFFF, offset=8'h01 -> mem_addr=16'h0000.
- **Fill and back-pressure:** output_ready=0, push 4 stores with ROB_entry 1..4 -> count=4, input_ready=0. A fifth input_valid is ignored. Then output_ready=1 -> ROB_entry_out sequence 1,2,3,4 on consecutive cycles, then output_valid=0.
- **Full with simultaneous pop:** count=4, output_ready=1, push ROB 5 -> count stays 4, and after draining the order is 2,3,4,5.
- **Reset mid-operation:** count=3, pulse rst_n low mid-cycle -> output_valid=0, count=0 immediately, without waiting for a clock. After release, push ROB 7 -> visible one cycle later as the only entry.
- **Flush (MEM_AGU_QUEUE_FLUSH_EN only):** count=2, assert flush with input_valid=1 -> next cycle count=0, output_valid=0, and the pushed entry is absent.
